// File: rtl/elastic_bram_load.sv
// Elastic load: address tokens drive a 1-cycle-latency BRAM read port, data returns in order.
// Optional address range check enabled by ELASTIC_BRAM_LOAD_BOUNDS_EN.
module elastic_bram_load #(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32,
    parameter int DEPTH        = 2,
    parameter int MEM_DEPTH    = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDRESS_SIZE-1:0] input_addr,
    input  logic                    pValidArray,
    output logic                    readyArray,
    output logic [DATA_SIZE-1:0]    dataOutArray,
    output logic                    validArray,
    input  logic                    nReadyArray,
    output logic [31:0]             bram_address,
    output logic                    bram_ce,
    input  logic [DATA_SIZE-1:0]    bram_din,
    output logic                    err_oob
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1) + 1;

    logic [DATA_SIZE-1:0] buffer [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [CW-1:0]        occ;
    logic                 inflight;
    logic                 inflight_oob;
    logic                 pop;
    logic                 accept;
    logic                 oob;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign validArray   = (count != '0);
    assign dataOutArray = buffer[rd_ptr];
    assign pop          = validArray & nReadyArray;

    // The read in flight already owns a slot, so it counts against capacity.
    assign occ        = count + CW'(inflight);
    assign readyArray = ~rst & ((occ - CW'(pop)) < CW'(DEPTH));
    assign accept     = pValidArray & readyArray;

    assign bram_address = 32'(input_addr);

`ifdef ELASTIC_BRAM_LOAD_BOUNDS_EN
    localparam int AW1 = ADDRESS_SIZE + 1;
    localparam logic [AW1-1:0] MEM_LIM = AW1'(MEM_DEPTH);

    logic err_q;

    assign oob     = ({1'b0, input_addr} >= MEM_LIM);
    assign err_oob = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept & oob) begin
            err_q <= 1'b1;
        end
    end
`else
    assign oob     = 1'b0;
    assign err_oob = 1'b0;
`endif

    assign bram_ce = accept & ~oob;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            inflight     <= 1'b0;
            inflight_oob <= 1'b0;
        end else begin
            inflight     <= accept;
            inflight_oob <= accept & oob;
            if (inflight) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(inflight) - CW'(pop);
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (inflight) begin
            buffer[wr_ptr] <= inflight_oob ? '0 : bram_din;
        end
    end

endmodule
